// File: rtl/axi_sim_slave_if.sv
// axi_sim_slave_if: AXI4 bus bundle between a master (core or bench) and the
// axi_sim_slave memory model.
//   Parameters: ADDR_W address width, DATA_W data width (32 or 64).
//   aw*/w*/b* : write address, write data and write response channels
//   ar*/r*    : read address and read data channels
//   modport slave  : seen from the memory model
//   modport master : seen from the driver of the bus
interface axi_sim_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_sim_slave.sv
// axi_sim_slave: AXI4 slave memory model for simulation tops.
// Configurable read/write latency, FIXED/INCR bursts, byte strobes, address
// range checking with SLVERR, and a tohost monitor for test result writes.
// The backing store mem[] is never cleared so a bench can preload it.
// Ports:
//   clk          clock
//   reset        synchronous, active-high
//   axi          AXI4 slave modport (aw/w/b/ar/r channels)
//   tohost_valid one-cycle pulse on a nonzero write to TOHOST_ADDR
//   tohost_data  value of that write, held until the next pulse
module axi_sim_slave #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                MEM_WORDS   = 65536,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h8000_0000,
  parameter int                RD_LAT      = 1,
  parameter int                WR_LAT      = 1,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h8000_1000
) (
  input  logic              clk,
  input  logic              reset,
  axi_sim_slave_if.slave    axi,
  output logic              tohost_valid,
  output logic [DATA_W-1:0] tohost_data
);
  localparam int         BYTES   = DATA_W / 8;
  localparam int         OFF_LSB = $clog2(BYTES);
  localparam int         IDX_W   = $clog2(MEM_WORDS);
  localparam logic [2:0] SIZE_OK = 3'(OFF_LSB);
  localparam logic [63:0] LO_ADDR = 64'(BASE_ADDR);
  localparam logic [63:0] HI_ADDR = LO_ADDR + 64'(MEM_WORDS) * 64'(BYTES);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (64'(a) >= LO_ADDR) && (64'(a) < HI_ADDR);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFF_LSB);
  endfunction

  function automatic logic cfg_ok(input logic [2:0] size, input logic [1:0] burst);
    return (size == SIZE_OK) && !burst[1];
  endfunction

  // Keeps both address READYs low during reset and for the reset-release edge.
  logic ready_en_reg;
  always_ff @(posedge clk) begin
    if (reset) ready_en_reg <= 1'b0;
    else       ready_en_reg <= 1'b1;
  end

  // ---------------------------------------------------------------- write side
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

  w_state_t          w_state_reg, w_state_next;
  logic [ADDR_W-1:0] w_addr_reg;
  logic              w_fixed_reg;
  logic              w_cfg_ok_reg;
  logic              w_err_reg;
  logic [15:0]       w_cnt_reg;
  logic              tohost_valid_reg;
  logic [DATA_W-1:0] tohost_data_reg;

  logic              awready_int, wready_int, bvalid_int;
  logic              aw_hs, w_hs, w_beat_err, mem_we, tohost_hit;
  logic [IDX_W-1:0]  w_idx;

  assign awready_int = (w_state_reg == W_IDLE) && ready_en_reg;
  assign wready_int  = (w_state_reg == W_DATA);
  assign bvalid_int  = (w_state_reg == W_RESP);
  assign aw_hs       = axi.awvalid && awready_int;
  // A beat seen during a reset cycle is abandoned, never committed.
  assign w_hs        = axi.wvalid && wready_int && !reset;
  assign w_beat_err  = !w_cfg_ok_reg || !in_range(w_addr_reg);
  assign mem_we      = w_hs && !w_beat_err;
  assign w_idx       = word_idx(w_addr_reg);
  assign tohost_hit  = w_hs && (w_addr_reg == TOHOST_ADDR) && (axi.wdata != '0);

  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE: if (aw_hs) w_state_next = W_DATA;
      W_DATA: if (w_hs && axi.wlast) w_state_next = (WR_LAT <= 1) ? W_RESP : W_WAIT;
      W_WAIT: if (w_cnt_reg >= 16'(WR_LAT - 2)) w_state_next = W_RESP;
      W_RESP: if (axi.bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_reg      <= W_IDLE;
      w_addr_reg       <= '0;
      w_fixed_reg      <= 1'b0;
      w_cfg_ok_reg     <= 1'b0;
      w_err_reg        <= 1'b0;
      w_cnt_reg        <= '0;
      tohost_valid_reg <= 1'b0;
      tohost_data_reg  <= '0;
    end else begin
      w_state_reg      <= w_state_next;
      tohost_valid_reg <= tohost_hit;
      if (tohost_hit) tohost_data_reg <= axi.wdata;
      if (aw_hs) begin
        w_addr_reg   <= axi.awaddr;
        w_fixed_reg  <= (axi.awburst == 2'b00);
        w_cfg_ok_reg <= cfg_ok(axi.awsize, axi.awburst);
        w_err_reg    <= 1'b0;
      end
      if (w_hs) begin
        w_err_reg <= w_err_reg | w_beat_err;
        if (!w_fixed_reg) w_addr_reg <= w_addr_reg + ADDR_W'(BYTES);
      end
      if (w_state_reg == W_WAIT) w_cnt_reg <= w_cnt_reg + 16'd1;
      else                       w_cnt_reg <= '0;
    end
  end

  // Byte-enable write port; no reset so preloaded contents survive.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read side
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  r_state_t          r_state_reg, r_state_next;
  logic [ADDR_W-1:0] r_addr_reg;
  logic [7:0]        r_len_reg;
  logic [7:0]        r_beat_reg;
  logic              r_fixed_reg;
  logic              r_cfg_ok_reg;
  logic [15:0]       r_cnt_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [1:0]        rresp_reg;
  logic              rlast_reg;

  logic              arready_int, rvalid_int, ar_hs, r_hs;
  // Beat load: registers the next beat into the R output registers.
  logic              ld_en, ld_cfg_ok, ld_err;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_beat, ld_len;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_word;

  assign arready_int = (r_state_reg == R_IDLE) && ready_en_reg;
  assign rvalid_int  = (r_state_reg == R_DATA);
  assign ar_hs       = axi.arvalid && arready_int;
  assign r_hs        = rvalid_int && axi.rready;

  always_comb begin
    r_state_next = r_state_reg;
    ld_en        = 1'b0;
    ld_addr      = r_addr_reg;
    ld_beat      = 8'd0;
    ld_len       = r_len_reg;
    ld_cfg_ok    = r_cfg_ok_reg;
    case (r_state_reg)
      R_IDLE: begin
        if (ar_hs) begin
          if (RD_LAT <= 1) begin
            // No wait state: load beat 0 straight from the AR channel.
            r_state_next = R_DATA;
            ld_en        = 1'b1;
            ld_addr      = axi.araddr;
            ld_len       = axi.arlen;
            ld_cfg_ok    = cfg_ok(axi.arsize, axi.arburst);
          end else begin
            r_state_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt_reg >= 16'(RD_LAT - 2)) begin
          r_state_next = R_DATA;
          ld_en        = 1'b1;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (rlast_reg) begin
            r_state_next = R_IDLE;
          end else begin
            ld_en   = 1'b1;
            ld_beat = r_beat_reg + 8'd1;
            if (!r_fixed_reg) ld_addr = r_addr_reg + ADDR_W'(BYTES);
          end
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  assign ld_err = !ld_cfg_ok || !in_range(ld_addr);
  assign ld_idx = word_idx(ld_addr);

  // A write committed on the same edge as a beat load is forwarded byte by
  // byte, so the loaded beat already reflects it.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_fwd
      assign ld_word[gi*8 +: 8] = (mem_we && (w_idx == ld_idx) && axi.wstrb[gi])
                                  ? axi.wdata[gi*8 +: 8] : mem[ld_idx][gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_reg  <= R_IDLE;
      r_addr_reg   <= '0;
      r_len_reg    <= '0;
      r_beat_reg   <= '0;
      r_fixed_reg  <= 1'b0;
      r_cfg_ok_reg <= 1'b0;
      r_cnt_reg    <= '0;
      rdata_reg    <= '0;
      rresp_reg    <= 2'b00;
      rlast_reg    <= 1'b0;
    end else begin
      r_state_reg <= r_state_next;
      if (ar_hs) begin
        r_addr_reg   <= axi.araddr;
        r_len_reg    <= axi.arlen;
        r_fixed_reg  <= (axi.arburst == 2'b00);
        r_cfg_ok_reg <= cfg_ok(axi.arsize, axi.arburst);
        r_cnt_reg    <= '0;
      end else if (r_state_reg == R_WAIT) begin
        r_cnt_reg <= r_cnt_reg + 16'd1;
      end
      if (ld_en) begin
        r_addr_reg <= ld_addr;
        r_beat_reg <= ld_beat;
        rdata_reg  <= ld_err ? '0 : ld_word;
        rresp_reg  <= ld_err ? 2'b10 : 2'b00;
        rlast_reg  <= (ld_beat == ld_len);
      end else if (r_hs && rlast_reg) begin
        rlast_reg <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------ outputs
  assign axi.awready  = awready_int;
  assign axi.wready   = wready_int;
  assign axi.bvalid   = bvalid_int;
  assign axi.bresp    = w_err_reg ? 2'b10 : 2'b00;
  assign axi.arready  = arready_int;
  assign axi.rvalid   = rvalid_int;
  assign axi.rdata    = rdata_reg;
  assign axi.rresp    = rresp_reg;
  assign axi.rlast    = rlast_reg;
  assign tohost_valid = tohost_valid_reg;
  assign tohost_data  = tohost_data_reg;
endmodule
